// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the clock-enable sequencer.
package clk_div_pkg;

    localparam int unsigned DefCntW      = 8;
    localparam int unsigned DefMaxDiv    = 200;
    localparam int unsigned DefResetDiv  = 2;
    localparam int unsigned DefSettleCyc = 2;

    // Sequencer control states.
    typedef enum logic [1:0] {
        StOff,
        StRun,
        StWaitEdge,
        StSettle
    } state_e;

endpackage

// File: rtl/clk_div_sequencer_if.sv
// Configuration handshake and enable outputs of the clock-enable sequencer.
interface clk_div_sequencer_if
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
);

    logic             cfg_req;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ack;
    logic             cfg_err;
    logic             clk_en;
    logic             clk_en_div2;
    logic [CNT_W-1:0] active_div;
    logic             busy;

    modport master (
        output cfg_req, cfg_div,
        input  cfg_ack, cfg_err, clk_en, clk_en_div2, active_div, busy
    );

    modport slave (
        input  cfg_req, cfg_div,
        output cfg_ack, cfg_err, clk_en, clk_en_div2, active_div, busy
    );

endinterface

// File: rtl/clk_div_counter.sv
// Period counter with registered enable pulse and half-rate enable.
module clk_div_counter
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_ratio,
    output logic             o_wrap,
    output logic             o_en,
    output logic             o_en_div2
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             r_en;
    logic             r_en_div2;
    logic             w_wrap;

    // Terminal count of the current period; a zero ratio never wraps.
    assign w_wrap = i_run && (i_ratio != '0) && (r_cnt == i_ratio - CNT_W'(1));

    // Count, register the pulse one cycle after terminal count, and track div2 phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_phase   <= 1'b0;
            r_en      <= 1'b0;
            r_en_div2 <= 1'b0;
        end else begin
            r_en      <= w_wrap;
            r_en_div2 <= w_wrap & r_phase;
            // Load wins over wrap so the final old pulse keeps its phase but the new
            // ratio starts from phase 0.
            if (i_load) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (w_wrap) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else if (i_run) begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_wrap    = w_wrap;
    assign o_en      = r_en;
    assign o_en_div2 = r_en_div2;

endmodule

// File: rtl/clk_div_sequencer.sv
// Ratio-change FSM and req/ack handshake around the enable counter.
module clk_div_sequencer
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned MAX_DIV    = DefMaxDiv,
    parameter int unsigned RESET_DIV  = DefResetDiv,
    parameter int unsigned SETTLE_CYC = DefSettleCyc
) (
    input  logic               i_sys_clk,
    input  logic               i_sys_rst_n,
    clk_div_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] MaxDivV   = CNT_W'(MAX_DIV);
    localparam logic [CNT_W-1:0] ResetDivV = CNT_W'(RESET_DIV);
    localparam int unsigned      SetW      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SetW-1:0]  SetLast   = SetW'(SETTLE_CYC - 1);
    localparam state_e           RstState  = (RESET_DIV != 0) ? StRun : StOff;

    state_e           r_state, w_state_d;
    logic             r_busy, w_busy_d;
    logic [CNT_W-1:0] r_div_req, w_div_req_d;
    logic [CNT_W-1:0] r_active_div, w_active_d;
    logic [SetW-1:0]  r_settle_cnt, w_settle_d;
    logic             w_load;
    logic             w_run;
    logic             w_ack;
    logic             w_err;
    logic             w_wrap;
    logic             w_en;
    logic             w_en_div2;

    // State and handshake registers.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state      <= RstState;
            r_busy       <= 1'b0;
            r_div_req    <= '0;
            r_active_div <= ResetDivV;
            r_settle_cnt <= '0;
        end else begin
            r_state      <= w_state_d;
            r_busy       <= w_busy_d;
            r_div_req    <= w_div_req_d;
            r_active_div <= w_active_d;
            r_settle_cnt <= w_settle_d;
        end
    end

    // Next-state, capture/decision and acknowledge decode.
    always_comb begin
        w_state_d   = r_state;
        w_busy_d    = r_busy;
        w_div_req_d = r_div_req;
        w_active_d  = r_active_div;
        w_settle_d  = r_settle_cnt;
        w_load      = 1'b0;
        w_run       = 1'b0;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            StOff, StRun: begin
                w_run = (r_state == StRun);
                // In RUN/OFF, a set busy flag marks the decision cycle after capture.
                if (r_busy) begin
                    if (r_div_req > MaxDivV) begin
                        w_ack    = 1'b1;
                        w_err    = 1'b1;
                        w_busy_d = 1'b0;
                    end else if (r_div_req == r_active_div) begin
                        w_ack    = 1'b1;
                        w_busy_d = 1'b0;
                    end else if (r_state == StRun) begin
                        w_state_d = StWaitEdge;
                    end else begin
                        w_state_d  = StSettle;
                        w_load     = 1'b1;
                        w_active_d = r_div_req;
                        w_settle_d = '0;
                    end
                end else if (bus.cfg_req) begin
                    w_busy_d    = 1'b1;
                    w_div_req_d = bus.cfg_div;
                end
            end
            StWaitEdge: begin
                w_run = 1'b1;
                if (w_wrap) begin
                    w_state_d  = StSettle;
                    w_load     = 1'b1;
                    w_active_d = r_div_req;
                    w_settle_d = '0;
                end
            end
            StSettle: begin
                if (r_settle_cnt == SetLast) begin
                    w_ack     = 1'b1;
                    w_busy_d  = 1'b0;
                    w_state_d = (r_active_div == '0) ? StOff : StRun;
                end else begin
                    w_settle_d = r_settle_cnt + SetW'(1);
                end
            end
            default: w_state_d = RstState;
        endcase
    end

    clk_div_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .i_clk     (i_sys_clk),
        .i_rst_n   (i_sys_rst_n),
        .i_load    (w_load),
        .i_run     (w_run),
        .i_ratio   (r_active_div),
        .o_wrap    (w_wrap),
        .o_en      (w_en),
        .o_en_div2 (w_en_div2)
    );

    assign bus.cfg_ack     = w_ack;
    assign bus.cfg_err     = w_err;
    assign bus.clk_en      = w_en;
    assign bus.clk_en_div2 = w_en_div2;
    assign bus.active_div  = r_active_div;
    assign bus.busy        = r_busy;

endmodule
